// File: rtl/huff_pkg.sv
// huff_pkg -- definitions shared by the Huffman decoder feed controller.
//
// Contents:
//   huff_state_t  : controller FSM states
//   HUFF_CHUNK_W  : default decoder chunk width (bits per transfer)
//   LEN_W         : width of the chunk-length field (values 1..4)
//   SYM_W         : width of the per-frame decoded-symbol counter
//   BITS_W        : width of the frame bit-count / remaining-bit counter
//   sat_inc()     : saturating increment used for the symbol counter
package huff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } huff_state_t;

    localparam int HUFF_CHUNK_W = 4;
    localparam int LEN_W        = 3;
    localparam int SYM_W        = 8;
    localparam int BITS_W       = 16;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [SYM_W-1:0] sat_inc(input logic [SYM_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/huff_chunk_slicer.sv
// huff_chunk_slicer -- holds one input word and presents it to the decoder
// CHUNK_W bits at a time, MSB first.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears word and index)
//   load_i     : capture word_i, restart at chunk 0
//   word_i     : incoming encoded word
//   adv_i      : current chunk consumed, move to the next one
//   rem_i      : bits still owed to the decoder for this frame
//   chunk_o    : current chunk, MSB first, bits beyond rem_i forced to 0
//   len_o      : valid bits in chunk_o = min(CHUNK_W, rem_i)
//   last_o     : current chunk is the final chunk of the word
module huff_chunk_slicer
    import huff_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int CHUNK_W = HUFF_CHUNK_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic               adv_i,
    input  logic [BITS_W-1:0]  rem_i,
    output logic [CHUNK_W-1:0] chunk_o,
    output logic [LEN_W-1:0]   len_o,
    output logic               last_o
);

    localparam int NCHUNK = WORD_W / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // The word is shifted left on each advance so the current chunk always
    // sits in the top CHUNK_W bits.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = '0;
        end else if (adv_i) begin
            word_d = word_q << CHUNK_W;
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign last_o = (idx_q == IDX_W'(NCHUNK - 1));

    always_comb begin
        len_o = (rem_i >= BITS_W'(CHUNK_W)) ? LEN_W'(CHUNK_W) : rem_i[LEN_W-1:0];
        // Keep only the top len_o bits so a short final chunk is zero-padded.
        for (int i = 0; i < CHUNK_W; i++) begin
            chunk_o[CHUNK_W-1-i] = word_q[WORD_W-1-i] & (LEN_W'(i) < len_o);
        end
    end

endmodule

// File: rtl/huff_feed_ctrl.sv
// huff_feed_ctrl -- feeds an encoded bit stream, word by word, into a
// Huffman decoder as CHUNK_W-bit chunks and tracks frame completion.
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   frame_start   : start-of-frame pulse (honoured in IDLE, DONE, ERR)
//   frame_bits    : total encoded bits in the frame
//   frame_syms    : decoded symbols expected for the frame
//   s_word_valid/s_word/s_word_ready : encoded word input handshake
//   dec_svalid/dec_in_bits/dec_in_len/dec_aready : chunk output handshake;
//                   dec_svalid is a one-cycle-gap pulse train
//   dec_tvalid    : decoder produced a symbol
//   busy          : frame in progress (FETCH/SEND/DRAIN)
//   done          : frame complete, held until next frame_start or reset
//   err_timeout   : decoder went quiet for TIMEOUT cycles while draining
//   sym_count     : symbols decoded this frame, saturating
//
// Build option: define HUFF_FEED_TIMEOUT_EN to include the drain watchdog.
// Without it err_timeout is tied low and DRAIN waits indefinitely.
module huff_feed_ctrl
    import huff_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int CHUNK_W = HUFF_CHUNK_W,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [BITS_W-1:0]  frame_bits,
    input  logic [SYM_W-1:0]   frame_syms,
    input  logic               s_word_valid,
    input  logic [WORD_W-1:0]  s_word,
    output logic               s_word_ready,
    output logic               dec_svalid,
    output logic [CHUNK_W-1:0] dec_in_bits,
    output logic [LEN_W-1:0]   dec_in_len,
    input  logic               dec_aready,
    input  logic               dec_tvalid,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic [SYM_W-1:0]   sym_count
);

    huff_state_t       state_q;
    logic [BITS_W-1:0] rem_q;
    logic [SYM_W-1:0]  syms_q;
    logic [SYM_W-1:0]  sym_q;
    logic              ready_q;
    logic              svalid_q;
    logic              busy_q;
    logic              done_q;
    logic              word_last;
    logic              load;
    logic              xfer;

`ifdef HUFF_FEED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
`else
    // TIMEOUT only matters when the drain watchdog is compiled in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    assign load = (state_q == ST_FETCH) && s_word_valid;
    assign xfer = (state_q == ST_SEND) && svalid_q && dec_aready;

    huff_chunk_slicer #(
        .WORD_W  (WORD_W),
        .CHUNK_W (CHUNK_W)
    ) u_slicer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .word_i  (s_word),
        .adv_i   (xfer),
        .rem_i   (rem_q),
        .chunk_o (dec_in_bits),
        .len_o   (dec_in_len),
        .last_o  (word_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            syms_q   <= '0;
            sym_q    <= '0;
            ready_q  <= 1'b0;
            svalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef HUFF_FEED_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            if (dec_tvalid && (state_q != ST_IDLE)) begin
                sym_q <= sat_inc(sym_q);
            end
`ifdef HUFF_FEED_TIMEOUT_EN
            // Quiet-cycle counter only runs while draining.
            if ((state_q == ST_DRAIN) && !dec_tvalid) begin
                tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end
`endif
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (frame_start) begin
                        rem_q  <= frame_bits;
                        syms_q <= frame_syms;
                        sym_q  <= '0;
`ifdef HUFF_FEED_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                        if (frame_bits == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_FETCH;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (s_word_valid) begin
                        ready_q  <= 1'b0;
                        svalid_q <= 1'b1;
                        state_q  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!svalid_q) begin
                        // Gap cycle after a transfer is over; offer next chunk.
                        svalid_q <= 1'b1;
                    end else if (dec_aready) begin
                        svalid_q <= 1'b0;
                        rem_q    <= rem_q - BITS_W'(dec_in_len);
                        if (rem_q == BITS_W'(dec_in_len)) begin
                            state_q <= ST_DRAIN;
                        end else if (word_last) begin
                            state_q <= ST_FETCH;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sym_q >= syms_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
`ifdef HUFF_FEED_TIMEOUT_EN
                    else if (!dec_tvalid && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_word_ready = ready_q;
    assign dec_svalid   = svalid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sym_count    = sym_q;
`ifdef HUFF_FEED_TIMEOUT_EN
    assign err_timeout  = err_q;
`else
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: doc/huff_feed_ctrl.md
HUFF_FEED_CTRL -- requirements
Module: huff_feed_ctrl

Interface
REQ-001 SHALL have parameters: WORD_W, 16, input word width; CHUNK_W, 4, decoder chunk width; TIMEOUT, 64, idle cycles in DRAIN before error.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- frame_start  in  1  start-of-frame pulse
- frame_bits  in  16  total encoded bits in frame
- frame_syms  in  8  expected decoded symbols
- s_word_valid  in  1  input word valid
- s_word  in  WORD_W  encoded bits, MSB first
- s_word_ready  out  1  word accepted when valid&&ready
- dec_svalid  out  1  chunk valid to decoder
- dec_in_bits  out  CHUNK_W  chunk, MSB first
- dec_in_len  out  3  valid bits in chunk (1..4)
- dec_aready  in  1  decoder ready
- dec_tvalid  in  1  decoder symbol strobe
- busy  out  1  frame in progress
- done  out  1  frame complete
- err_timeout  out  1  drain timeout
- sym_count  out  8  symbols decoded this frame

Function
REQ-003 SHALL implement FSM IDLE, FETCH, SEND, DRAIN, DONE, ERR.
REQ-004 IDLE: frame_start latches frame_bits/frame_syms, clears sym_count, done, err_timeout -> FETCH; frame_bits==0 -> DONE directly.
REQ-005 frame_start SHALL be ignored outside IDLE, DONE, ERR; in DONE/ERR it starts a new frame as in IDLE.
REQ-006 FETCH: s_word_ready=1; on accept, word loaded into slice register, chunk index 0 -> SEND.
REQ-007 SEND: dec_svalid=1 with dec_in_bits = next CHUNK_W bits MSB-first; chunk transferred only on cycle with dec_svalid&&dec_aready; outputs SHALL be stable until then.
REQ-008 Each transfer SHALL subtract dec_in_len from remaining-bit counter; dec_in_len = min(CHUNK_W, remaining); unused LSBs of last chunk SHALL be 0.
REQ-009 After transfer: remaining==0 -> DRAIN; word exhausted (WORD_W/CHUNK_W chunks sent) -> FETCH; else stay SEND with next chunk.
REQ-010 After each transfer dec_svalid SHALL drop for at least one cycle (decoder samples one-cycle pulses).
REQ-011 dec_tvalid SHALL increment sym_count in any non-IDLE state, saturating at 255; simultaneous with a chunk transfer, both take effect.
REQ-012 DRAIN: sym_count>=frame_syms -> DONE; done=1 held until next frame_start or reset.
REQ-013 Extra s_word beyond frame_bits SHALL NOT be accepted (s_word_ready=0 outside FETCH).
REQ-014 busy=1 in FETCH, SEND, DRAIN; else 0.

Reset
REQ-015 reset SHALL asynchronously force IDLE; all outputs 0; counters and slice register cleared.
REQ-016 reset mid-frame SHALL drop dec_svalid immediately; no partial chunk reissued after release.

Configuration
REQ-017 With HUFF_FEED_TIMEOUT_EN defined: DRAIN counts cycles without dec_tvalid, cleared on each dec_tvalid; reaching TIMEOUT -> ERR, err_timeout=1 held until frame_start/reset.
REQ-018 Without HUFF_FEED_TIMEOUT_EN: no counter, err_timeout tied 0, ERR unreachable, DRAIN waits indefinitely.

Structure
REQ-019 Shared package huff_pkg SHALL hold FSM state enum, CHUNK_W, LEN_W (3) and symbol-count width.
REQ-020 Sub-module huff_chunk_slicer (word register, chunk index, MSB-first slice, zero padding) SHALL be used; FSM and counters stay in top.

Verification
REQ-021 Frame 23 bits/4 syms, words 16'hF97C, 16'h3C00 -> chunks 1111,1001,0111,1100,0011 len 4, then 110 (bits 4'b1100) len 3; with decoder, sym_count=4 and done=1.
REQ-022 dec_aready low 5 cycles during SEND -> dec_svalid and dec_in_bits held constant, exactly one transfer on release.
REQ-023 frame_bits=0 -> done=1 next cycle, no s_word_ready or dec_svalid.
REQ-024 TIMEOUT_EN, frame_syms=5 on 4-symbol stream -> err_timeout=1 exactly 64 cycles after last dec_tvalid.
REQ-025 reset asserted mid-SEND -> outputs 0 same cycle; new frame_start after release decodes first frame correctly.
REQ-026 dec_tvalid coincident with chunk transfer -> sym_count +1 and remaining bits reduced same cycle.
